// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared LSU definitions: aluop codes, exception causes, dcache op encodings and op classification helpers.
// Used by lsu_mem_ctrl (optional alignment check via LSU_ALE_CHECK_EN) and lsu_align_unit.
package lsu_mem_ctrl_pkg;

    localparam logic [7:0] ALU_LDB   = 8'h20;
    localparam logic [7:0] ALU_LDH   = 8'h21;
    localparam logic [7:0] ALU_LDW   = 8'h22;
    localparam logic [7:0] ALU_LDBU  = 8'h23;
    localparam logic [7:0] ALU_LDHU  = 8'h24;
    localparam logic [7:0] ALU_STB   = 8'h25;
    localparam logic [7:0] ALU_STH   = 8'h26;
    localparam logic [7:0] ALU_STW   = 8'h27;
    localparam logic [7:0] ALU_CACOP = 8'h28;

    localparam logic [6:0] EXCEPTION_ALE = 7'h09;

    localparam logic [1:0] DC_OP_LOAD  = 2'b00;
    localparam logic [1:0] DC_OP_STORE = 2'b01;
    localparam logic [1:0] DC_OP_CACOP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_EXC,
        S_CANCEL
    } lsu_state_e;

    function automatic logic op_known(input logic [7:0] op);
        return (op >= ALU_LDB) && (op <= ALU_CACOP);
    endfunction

    function automatic logic [1:0] op_kind(input logic [7:0] op);
        if (op == ALU_STB || op == ALU_STH || op == ALU_STW) return DC_OP_STORE;
        if (op == ALU_CACOP)                                 return DC_OP_CACOP;
        return DC_OP_LOAD;
    endfunction

    function automatic logic op_misaligned(input logic [7:0] op, input logic [1:0] a);
        logic half, word;
        half = (op == ALU_LDH) || (op == ALU_LDHU) || (op == ALU_STH);
        word = (op == ALU_LDW) || (op == ALU_STW);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane steering: store strobes/replicated write data and load byte/half selection with extension.
module lsu_align_unit
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = rdata_i >> {addr_lo_i, 3'b000};
    assign half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = sdata_i;
        case (aluop_i)
            ALU_STB: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{sdata_i[7:0]}};
            end
            ALU_STH: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{sdata_i[15:0]}};
            end
            ALU_STW: wstrb_o = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        ldata_o = '0;
        case (aluop_i)
            ALU_LDB:  ldata_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
            ALU_LDBU: ldata_o = {24'h0, byte_sh[7:0]};
            ALU_LDH:  ldata_o = {{16{half_sh[15]}}, half_sh[15:0]};
            ALU_LDHU: ldata_o = {16'h0, half_sh[15:0]};
            ALU_LDW:  ldata_o = rdata_i;
            default:  ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding LSU sequencer between EX and the dcache req/addr_ok/data_ok bus.
// Define LSU_ALE_CHECK_EN to raise ALE on misaligned half/word accesses instead of issuing them.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [7:0]          ex_aluop,
    input  logic [ADDR_W-1:0]   ex_base,
    input  logic [ADDR_W-1:0]   ex_imm,
    input  logic [DATA_W-1:0]   ex_sdata,
    input  logic [4:0]          ex_rd,
    input  logic                flush,
    output logic                dc_req,
    output logic [1:0]          dc_op,
    output logic [ADDR_W-1:0]   dc_addr,
    output logic [DATA_W/8-1:0] dc_wstrb,
    output logic [DATA_W-1:0]   dc_wdata,
    output logic [4:0]          dc_cacop_code,
    input  logic                dc_addr_ok,
    input  logic                dc_data_ok,
    input  logic [DATA_W-1:0]   dc_rdata,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                excp_valid,
    output logic [6:0]          excp_cause,
    output logic [ADDR_W-1:0]   excp_badv,
    output logic                busy
);

`ifdef LSU_ALE_CHECK_EN
    localparam bit ALE_EN = 1'b1;
`else
    localparam bit ALE_EN = 1'b0;
`endif

    lsu_state_e          state_q, state_d;
    logic [7:0]          aluop_q;
    logic [4:0]          rd_q;
    logic [DATA_W-1:0]   sdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   ea;
    logic                accept;
    logic                cap_rdata;
    logic                is_store;

    assign ea       = ex_base + ex_imm;
    assign is_store = (op_kind(aluop_q) == DC_OP_STORE);

    // An op presented alongside a flush belongs to the flushed stream and is not taken.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        cap_rdata = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && !flush && op_known(ex_aluop)) begin
                    accept  = 1'b1;
                    state_d = (ALE_EN && op_misaligned(ex_aluop, ea[1:0])) ? S_EXC : S_REQ;
                end
            end
            S_REQ: begin
                if (flush)
                    state_d = (dc_addr_ok && !is_store) ? S_CANCEL : S_IDLE;
                else if (dc_addr_ok)
                    state_d = is_store ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (dc_data_ok) begin
                    state_d   = flush ? S_IDLE : S_DONE;
                    cap_rdata = !flush;
                end else if (flush) begin
                    state_d = S_CANCEL;
                end
            end
            S_DONE, S_EXC: state_d = S_IDLE;
            S_CANCEL: if (dc_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            aluop_q <= '0;
            rd_q    <= '0;
            sdata_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                aluop_q <= ex_aluop;
                rd_q    <= ex_rd;
                sdata_q <= ex_sdata;
                addr_q  <= ea;
            end
            if (cap_rdata) rdata_q <= dc_rdata;
        end
    end

    logic [31:0] ldata;

    lsu_align_unit u_align (
        .aluop_i   (aluop_q),
        .addr_lo_i (addr_q[1:0]),
        .sdata_i   (sdata_q),
        .rdata_i   (rdata_q),
        .wstrb_o   (dc_wstrb),
        .wdata_o   (dc_wdata),
        .ldata_o   (ldata)
    );

    assign ex_ready      = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign dc_req        = (state_q == S_REQ);
    assign dc_op         = op_kind(aluop_q);
    assign dc_addr       = addr_q;
    assign dc_cacop_code = rd_q;

    assign wb_valid   = (state_q == S_DONE) && !flush;
    assign wb_we      = wb_valid && (op_kind(aluop_q) == DC_OP_LOAD);
    assign wb_rd      = rd_q;
    assign wb_data    = ldata;
    assign excp_valid = (state_q == S_EXC) && !flush;
    assign excp_cause = excp_valid ? EXCEPTION_ALE : 7'h00;
    assign excp_badv  = addr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized ops against a transaction-level model.
// Honours LSU_ALE_CHECK_EN the same way the design does.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, flush;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_base, ex_imm, ex_sdata;
    logic [4:0]  ex_rd;
    logic        dc_req, dc_addr_ok, dc_data_ok;
    logic [1:0]  dc_op;
    logic [31:0] dc_addr, dc_wdata, dc_rdata;
    logic [3:0]  dc_wstrb;
    logic [4:0]  dc_cacop_code, wb_rd;
    logic        wb_valid, wb_we, excp_valid, busy;
    logic [31:0] wb_data, excp_badv;
    logic [6:0]  excp_cause;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluop(ex_aluop),
        .ex_base(ex_base), .ex_imm(ex_imm), .ex_sdata(ex_sdata), .ex_rd(ex_rd),
        .flush(flush),
        .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_wstrb(dc_wstrb),
        .dc_wdata(dc_wdata), .dc_cacop_code(dc_cacop_code),
        .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .excp_valid(excp_valid), .excp_cause(excp_cause), .excp_badv(excp_badv),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic straight from the op definitions.
    function automatic int m_kind(input logic [7:0] op);
        if (op == ALU_STB || op == ALU_STH || op == ALU_STW) return 1;
        if (op == ALU_CACOP) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [7:0] op, input logic [31:0] a);
        int off = int'(a % 4);
        if (op == ALU_STB) return 4'(1 << off);
        if (op == ALU_STH) return 4'(3 << ((off / 2) * 2));
        if (op == ALU_STW) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] sd);
        if (op == ALU_STB) return (sd & 32'hFF) * 32'h0101_0101;
        if (op == ALU_STH) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
        int off = int'(a % 4);
        logic [31:0] b, h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        if (op == ALU_LDB)  return b + ((b >= 128) ? 32'hFFFF_FF00 : 32'h0);
        if (op == ALU_LDBU) return b;
        if (op == ALU_LDH)  return h + ((h >= 32768) ? 32'hFFFF_0000 : 32'h0);
        if (op == ALU_LDHU) return h;
        return rd;
    endfunction

    function automatic bit m_mis(input logic [7:0] op, input logic [31:0] a);
        if (op == ALU_LDH || op == ALU_LDHU || op == ALU_STH) return (a % 2) != 0;
        if (op == ALU_LDW || op == ALU_STW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Drives one op and a dcache responder with the given handshake delays, checking every cycle.
    task automatic run_op(input logic [7:0] op, input logic [31:0] base, input logic [31:0] imm,
                          input logic [31:0] sd, input logic [4:0] rd, input int ad, input int dd,
                          input logic [31:0] rdat);
        logic [31:0] a = base + imm;
        int k = m_kind(op);
        @(negedge clk);
        ex_valid = 1'b1; ex_aluop = op; ex_base = base; ex_imm = imm; ex_sdata = sd; ex_rd = rd;
        @(negedge clk);
        ex_valid = 1'b0; ex_base = $urandom; ex_sdata = $urandom; ex_rd = 5'($urandom);
`ifdef LSU_ALE_CHECK_EN
        if (m_mis(op, a)) begin
            check("ale_valid", 32'(excp_valid), 32'd1);
            check("ale_cause", 32'(excp_cause), 32'(EXCEPTION_ALE));
            check("ale_badv", excp_badv, a);
            check("ale_noreq", 32'(dc_req), 32'd0);
            @(negedge clk);
            check("ale_once", 32'(excp_valid), 32'd0);
            check("ale_ready", 32'(ex_ready), 32'd1);
            return;
        end
`endif
        check("req", 32'(dc_req), 32'd1);
        check("ready_lo", 32'(ex_ready), 32'd0);
        check("addr", dc_addr, a);
        check("dcop", 32'(dc_op), 32'(k));
        if (k == 1) begin
            check("wstrb", 32'(dc_wstrb), 32'(m_strb(op, a)));
            check("wdata", dc_wdata, m_wdata(op, sd));
        end
        if (k == 2) check("cacop_code", 32'(dc_cacop_code), 32'(rd));
        repeat (ad) begin
            @(negedge clk);
            check("req_hold", 32'(dc_req), 32'd1);
            check("addr_hold", dc_addr, a);
            check("ready_hold", 32'(ex_ready), 32'd0);
        end
        dc_addr_ok = 1'b1;
        @(negedge clk);
        dc_addr_ok = 1'b0;
        if (k != 1) begin
            check("wait_noreq", 32'(dc_req), 32'd0);
            repeat (dd) begin
                check("wait_nowb", 32'(wb_valid), 32'd0);
                @(negedge clk);
            end
            dc_data_ok = 1'b1; dc_rdata = rdat;
            @(negedge clk);
            dc_data_ok = 1'b0; dc_rdata = $urandom;
        end
        check("wb_valid", 32'(wb_valid), 32'd1);
        check("wb_we", 32'(wb_we), (k == 0) ? 32'd1 : 32'd0);
        check("wb_rd", 32'(wb_rd), 32'(rd));
        if (k == 0) check("wb_data", wb_data, m_load(op, a, rdat));
        @(negedge clk);
        check("wb_once", 32'(wb_valid), 32'd0);
        check("ready_back", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ops [9];
        ops = '{ALU_LDB, ALU_LDH, ALU_LDW, ALU_LDBU, ALU_LDHU, ALU_STB, ALU_STH, ALU_STW, ALU_CACOP};
        rst_n = 1'b0; ex_valid = 1'b0; ex_aluop = '0; ex_base = '0; ex_imm = '0; ex_sdata = '0;
        ex_rd = '0; flush = 1'b0; dc_addr_ok = 1'b0; dc_data_ok = 1'b0; dc_rdata = '0;
        #23;
        check("rst_ready", 32'(ex_ready), 32'd1);
        check("rst_req", 32'(dc_req), 32'd0);
        check("rst_wb", 32'(wb_valid), 32'd0);
        check("rst_excp", 32'(excp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", dc_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed examples.
        run_op(ALU_LDB, 32'h1000, 32'h3, 32'h0, 5'd7, 0, 0, 32'h80AABBCC);
        run_op(ALU_LDHU, 32'h1000, 32'h2, 32'h0, 5'd9, 0, 1, 32'h8001_1234);
        run_op(ALU_STH, 32'h2000, 32'h2, 32'h0000_1234, 5'd3, 0, 0, 32'h0);
        run_op(ALU_LDW, 32'h1010, 32'hFFFF_FFF0, 32'h0, 5'd4, 3, 0, 32'hDEAD_BEEF);
        run_op(ALU_LDW, 32'h1000, 32'h2, 32'h0, 5'd5, 0, 0, 32'h1357_9BDF);
        run_op(ALU_CACOP, 32'h4000, 32'h0, 32'h0, 5'd17, 1, 2, 32'h0);

        // Unknown aluop is dropped.
        @(negedge clk); ex_valid = 1'b1; ex_aluop = 8'hFF;
        @(negedge clk); ex_valid = 1'b0;
        check("unk_ready", 32'(ex_ready), 32'd1);
        check("unk_noreq", 32'(dc_req), 32'd0);

        // Flush in REQ before addr_ok: back to idle, no request left.
        @(negedge clk); ex_valid = 1'b1; ex_aluop = ALU_LDW; ex_base = 32'h3000; ex_imm = 32'h0;
        @(negedge clk); ex_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("fl_req_ready", 32'(ex_ready), 32'd1);
        check("fl_req_noreq", 32'(dc_req), 32'd0);
        @(negedge clk);
        check("fl_req_nowb", 32'(wb_valid), 32'd0);

        // Flush in WAIT, data_ok two cycles later.
        @(negedge clk); ex_valid = 1'b1; ex_aluop = ALU_LDW; ex_base = 32'h3000; ex_imm = 32'h4;
        @(negedge clk); ex_valid = 1'b0; dc_addr_ok = 1'b1;
        @(negedge clk); dc_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("cancel_nowb0", 32'(wb_valid), 32'd0);
        check("cancel_busy", 32'(ex_ready), 32'd0);
        @(negedge clk); dc_data_ok = 1'b1; dc_rdata = 32'hFFFF_FFFF;
        check("cancel_nowb1", 32'(wb_valid), 32'd0);
        @(negedge clk); dc_data_ok = 1'b0;
        check("cancel_nowb2", 32'(wb_valid), 32'd0);
        check("cancel_ready", 32'(ex_ready), 32'd1);

        // Flush while the store result is due suppresses the strobe.
        @(negedge clk); ex_valid = 1'b1; ex_aluop = ALU_STW; ex_base = 32'h5000; ex_imm = 32'h0;
        @(negedge clk); ex_valid = 1'b0; dc_addr_ok = 1'b1;
        @(negedge clk); dc_addr_ok = 1'b0; flush = 1'b1;
        #1 check("fl_done_nowb", 32'(wb_valid), 32'd0);
        @(negedge clk); flush = 1'b0;
        check("fl_done_ready", 32'(ex_ready), 32'd1);
        check("fl_done_nowb2", 32'(wb_valid), 32'd0);

        // Flush in IDLE: the concurrent op is not taken, the next one is.
        @(negedge clk); ex_valid = 1'b1; ex_aluop = ALU_LDBU; ex_base = 32'h6000; ex_imm = 32'h1; ex_rd = 5'd11; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("fl_idle_ready", 32'(ex_ready), 32'd1);
        check("fl_idle_noreq", 32'(dc_req), 32'd0);
        @(negedge clk); ex_valid = 1'b0;
        check("fl_idle_req", 32'(dc_req), 32'd1);
        check("fl_idle_addr", dc_addr, 32'h6001);
        dc_addr_ok = 1'b1;
        @(negedge clk); dc_addr_ok = 1'b0; dc_data_ok = 1'b1; dc_rdata = 32'h0000_9A00;
        @(negedge clk); dc_data_ok = 1'b0;
        check("fl_idle_wb", 32'(wb_valid), 32'd1);
        check("fl_idle_data", wb_data, 32'h0000_009A);
        @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic [11:0] imm12;
            imm12 = 12'($urandom);
            run_op(ops[$urandom_range(0, 8)], $urandom, {{20{imm12[11]}}, imm12}, $urandom,
                   5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
